// File: rtl/vector_sequencer.sv
// vector_sequencer: holds a DUT in reset, then plays a writable table of {reset level, switch pattern}
// vectors and folds the DUT display into a rotate-XOR signature. Optional: VECTOR_SEQUENCER_EXPECT_CHECK_EN.
module vector_sequencer #(
  parameter int SW_WIDTH     = 5,
  parameter int DISP_WIDTH   = 8,
  parameter int SIG_WIDTH    = 16,
  parameter int NUM_VECTORS  = 16,
  parameter int HOLD_CYCLES  = 1,
  parameter int RESET_CYCLES = 2
) (
  input  logic                                 Clock,
  input  logic                                 Resetn,
  input  logic                                 start,
  input  logic                                 vec_wr_en,
  input  logic [$clog2(NUM_VECTORS)-1:0]       vec_wr_addr,
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
  input  logic [SW_WIDTH+DISP_WIDTH:0]         vec_wr_data,
  output logic [$clog2(NUM_VECTORS+1)-1:0]     fail_count,
  output logic [$clog2(NUM_VECTORS)-1:0]       first_fail_index,
  output logic                                 pass,
`else
  input  logic [SW_WIDTH:0]                    vec_wr_data,
`endif
  output logic                                 dut_resetn_out,
  output logic [SW_WIDTH-1:0]                  sw_out,
  input  logic [DISP_WIDTH-1:0]                display_in,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(NUM_VECTORS)-1:0]       vec_index,
  output logic [SIG_WIDTH-1:0]                 signature
);

  localparam int IDX_W   = $clog2(NUM_VECTORS);
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
  localparam int ENTRY_W = SW_WIDTH + 1 + DISP_WIDTH;
  localparam int FC_W    = $clog2(NUM_VECTORS + 1);
`else
  localparam int ENTRY_W = SW_WIDTH + 1;
`endif
  localparam int CNT_MAX = (RESET_CYCLES > HOLD_CYCLES) ? RESET_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RST_DUT = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [SW_WIDTH-1:0]  sw_q, sw_d;
  logic                 rstn_q, rstn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Table storage is deliberately outside the reset domain so a Resetn pulse keeps the program.
  logic [ENTRY_W-1:0]   table_q [NUM_VECTORS];

  logic                 start_acc;
  logic                 sample;
  logic                 last_idx;
  logic [IDX_W-1:0]     next_idx;

  function automatic logic [SIG_WIDTH-1:0] sig_update(input logic [SIG_WIDTH-1:0] sig,
                                                      input logic [DISP_WIDTH-1:0] disp);
    return {sig[SIG_WIDTH-2:0], sig[SIG_WIDTH-1]} ^ SIG_WIDTH'(disp);
  endfunction

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign sample    = (state_q == RUN) && (cnt_q == CNT_W'(1));
  assign last_idx  = (idx_q == IDX_W'(NUM_VECTORS - 1));
  assign next_idx  = idx_q + IDX_W'(1);

  always_ff @(posedge Clock) begin
    if (vec_wr_en && !busy_q) begin
      table_q[vec_wr_addr] <= vec_wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    sw_d    = sw_q;
    rstn_d  = rstn_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = RST_DUT;
          cnt_d   = CNT_W'(RESET_CYCLES);
          idx_d   = '0;
          sig_d   = '0;
          sw_d    = '0;
          rstn_d  = 1'b0;
        end
      end
      RST_DUT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = CNT_W'(HOLD_CYCLES);
          idx_d   = '0;
          sw_d    = table_q[0][SW_WIDTH-1:0];
          rstn_d  = table_q[0][SW_WIDTH];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (sample) begin
          sig_d = sig_update(sig_q, display_in);
          if (last_idx) begin
            // Last vector stays on the outputs while DONE.
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            idx_d  = next_idx;
            cnt_d  = CNT_W'(HOLD_CYCLES);
            sw_d   = table_q[next_idx][SW_WIDTH-1:0];
            rstn_d = table_q[next_idx][SW_WIDTH];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RST_DUT) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sig_q   <= '0;
      sw_q    <= '0;
      rstn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      sw_q    <= sw_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dut_resetn_out = rstn_q;
  assign sw_out         = sw_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign vec_index      = idx_q;
  assign signature      = sig_q;

`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
  logic [FC_W-1:0]       fc_q, fc_d;
  logic [IDX_W-1:0]      ffi_q, ffi_d;
  logic                  pass_q, pass_d;
  logic [DISP_WIDTH-1:0] exp_disp;

  assign exp_disp = table_q[idx_q][ENTRY_W-1 -: DISP_WIDTH];

  // Comparison happens on the same edge that folds display_in into the signature.
  always_comb begin
    fc_d  = fc_q;
    ffi_d = ffi_q;
    if (start_acc) begin
      fc_d  = '0;
      ffi_d = '0;
    end else if (sample && (display_in != exp_disp)) begin
      if (fc_q == '0) begin
        ffi_d = idx_q;
      end
      if (fc_q != '1) begin
        fc_d = fc_q + FC_W'(1);
      end
    end
    pass_d = done_d && (fc_d == '0);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      fc_q   <= '0;
      ffi_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      fc_q   <= fc_d;
      ffi_q  <= ffi_d;
      pass_q <= pass_d;
    end
  end

  assign fail_count       = fc_q;
  assign first_fail_index = ffi_q;
  assign pass             = pass_q;
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer (N=4, HOLD=2, RESET=2): per-cycle expected snapshots are
// queued at start and popped against the outputs; covers VECTOR_SEQUENCER_EXPECT_CHECK_EN when defined.
module tb_vector_sequencer;

  localparam int SW    = 5;
  localparam int DW    = 8;
  localparam int SGW   = 16;
  localparam int N     = 4;
  localparam int H     = 2;
  localparam int R     = 2;
  localparam int IW    = $clog2(N);
  localparam int FW    = $clog2(N + 1);
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
  localparam int EW    = SW + 1 + DW;
`else
  localparam int EW    = SW + 1;
`endif
  localparam int TOTAL = R + N * H + 2;

  logic           Clock;
  logic           Resetn;
  logic           start;
  logic           vec_wr_en;
  logic [IW-1:0]  vec_wr_addr;
  logic [EW-1:0]  vec_wr_data;
  logic           dut_resetn_out;
  logic [SW-1:0]  sw_out;
  logic [DW-1:0]  display_in;
  logic           busy;
  logic           done;
  logic [IW-1:0]  vec_index;
  logic [SGW-1:0] signature;
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
  logic [FW-1:0]  fail_count;
  logic [IW-1:0]  first_fail_index;
  logic           pass;
`endif

  vector_sequencer #(
    .SW_WIDTH(SW), .DISP_WIDTH(DW), .SIG_WIDTH(SGW),
    .NUM_VECTORS(N), .HOLD_CYCLES(H), .RESET_CYCLES(R)
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .start(start),
    .vec_wr_en(vec_wr_en),
    .vec_wr_addr(vec_wr_addr),
    .vec_wr_data(vec_wr_data),
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
    .fail_count(fail_count),
    .first_fail_index(first_fail_index),
    .pass(pass),
`endif
    .dut_resetn_out(dut_resetn_out),
    .sw_out(sw_out),
    .display_in(display_in),
    .busy(busy),
    .done(done),
    .vec_index(vec_index),
    .signature(signature)
  );

  typedef struct packed {
    logic           busy;
    logic           done;
    logic           rstn;
    logic [SW-1:0]  sw;
    logic [IW-1:0]  idx;
    logic [SGW-1:0] sig;
    logic [FW-1:0]  fc;
    logic [IW-1:0]  ffi;
    logic           pass;
  } snap_t;

  snap_t         exp_q[$];
  logic [EW-1:0] mdl_tbl [N];
  int            n_cmp = 0;
  int            n_mis = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic r, input logic [SW-1:0] s, input logic [DW-1:0] x);
    return EW'({x, r, s});
  endfunction

  // Expected outputs for cycles T+1 .. T+TOTAL after start is sampled at edge T.
  function automatic void build_expect(input logic [DW-1:0] disp);
    for (int c = 1; c <= TOTAL; c++) begin
      snap_t          s;
      int             k;
      int             ns;
      int             fc;
      int             ffi;
      logic [SGW-1:0] sg;
      s  = '0;
      k  = 0;
      ns = 0;
      if (c <= R) begin
        s.busy = 1'b1;
      end else if ((c - 1 - R) < N * H) begin
        k      = (c - 1 - R) / H;
        ns     = k;
        s.busy = 1'b1;
      end else begin
        k      = N - 1;
        ns     = N;
        s.done = 1'b1;
      end
      if (c > R) begin
        s.rstn = mdl_tbl[k][SW];
        s.sw   = mdl_tbl[k][SW-1:0];
        s.idx  = IW'(k);
      end
      sg  = '0;
      fc  = 0;
      ffi = 0;
      for (int j = 0; j < ns; j++) begin
        sg = {sg[SGW-2:0], sg[SGW-1]} ^ SGW'(disp);
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
        if (disp != mdl_tbl[j][EW-1 -: DW]) begin
          if (fc == 0) ffi = j;
          fc++;
        end
`endif
      end
      s.sig  = sg;
      s.fc   = FW'(fc);
      s.ffi  = IW'(ffi);
      s.pass = s.done && (fc == 0);
      exp_q.push_back(s);
    end
  endfunction

  task automatic check_reset(input string tag);
    check_val({tag, " ctrl"}, 32'({busy, done, dut_resetn_out}), 32'(0));
    check_val({tag, " sw"}, 32'(sw_out), 32'(0));
    check_val({tag, " idx"}, 32'(vec_index), 32'(0));
    check_val({tag, " sig"}, 32'(signature), 32'(0));
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
    check_val({tag, " chk"}, 32'({fail_count, first_fail_index, pass}), 32'(0));
`endif
  endtask

  task automatic write_vec(input int a, input logic [EW-1:0] d);
    @(negedge Clock);
    vec_wr_en   = 1'b1;
    vec_wr_addr = IW'(a);
    vec_wr_data = d;
    mdl_tbl[a]  = d;
    @(negedge Clock);
    vec_wr_en   = 1'b0;
  endtask

  task automatic do_run(input string name, input logic [DW-1:0] disp, input bit noise,
                        input bit wr_with_start, input int wa, input logic [EW-1:0] wd);
    snap_t e;
    @(negedge Clock);
    start      = 1'b1;
    display_in = disp;
    if (wr_with_start) begin
      vec_wr_en   = 1'b1;
      vec_wr_addr = IW'(wa);
      vec_wr_data = wd;
      mdl_tbl[wa] = wd;
    end
    build_expect(disp);
    @(negedge Clock);
    start     = 1'b0;
    vec_wr_en = 1'b0;
    for (int c = 1; c <= TOTAL; c++) begin
      if (exp_q.size() == 0) begin
        check_val($sformatf("%s c%0d queue_empty", name, c), 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("%s c%0d ctrl", name, c), 32'({busy, done, dut_resetn_out}),
                  32'({e.busy, e.done, e.rstn}));
        check_val($sformatf("%s c%0d sw", name, c), 32'(sw_out), 32'(e.sw));
        check_val($sformatf("%s c%0d idx", name, c), 32'(vec_index), 32'(e.idx));
        check_val($sformatf("%s c%0d sig", name, c), 32'(signature), 32'(e.sig));
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
        check_val($sformatf("%s c%0d chk", name, c), 32'({fail_count, first_fail_index, pass}),
                  32'({e.fc, e.ffi, e.pass}));
`endif
      end
      // Stray start pulses and table writes while busy must have no effect.
      if (noise && (c < R + N * H)) begin
        start       = c[0];
        vec_wr_en   = 1'b1;
        vec_wr_addr = '0;
        vec_wr_data = EW'($urandom);
      end else begin
        start     = 1'b0;
        vec_wr_en = 1'b0;
      end
      @(negedge Clock);
    end
    start     = 1'b0;
    vec_wr_en = 1'b0;
  endtask

  initial begin
    Resetn      = 1'b0;
    start       = 1'b0;
    vec_wr_en   = 1'b0;
    vec_wr_addr = '0;
    vec_wr_data = '0;
    display_in  = '0;

    repeat (3) begin
      @(negedge Clock);
      start      = 1'($urandom);
      display_in = DW'($urandom);
      #1;
      check_reset("reset");
    end
    @(negedge Clock);
    Resetn = 1'b1;
    start  = 1'b0;

    write_vec(0, mk(1'b1, 5'b00001, 8'h01));
    write_vec(1, mk(1'b1, 5'b00010, 8'h01));
    write_vec(2, mk(1'b0, 5'b00000, 8'h02));
    write_vec(3, mk(1'b1, 5'b11111, 8'h01));
    @(negedge Clock);
    check_reset("idle");

    do_run("disp00", 8'h00, 1'b0, 1'b0, 0, '0);
    check_val("disp00 final sig", 32'(signature), 32'h0000);

    do_run("disp01", 8'h01, 1'b0, 1'b0, 0, '0);
    check_val("disp01 final sig", 32'(signature), 32'h000F);
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
    check_val("disp01 fail_count", 32'(fail_count), 32'(1));
    check_val("disp01 first_fail", 32'(first_fail_index), 32'(2));
    check_val("disp01 pass", 32'(pass), 32'(0));
`endif

    do_run("noise", 8'hA5, 1'b1, 1'b0, 0, '0);
    do_run("rerun", 8'h3C, 1'b0, 1'b0, 0, '0);

    do_run("wr_start", 8'h01, 1'b0, 1'b1, 2, mk(1'b1, 5'b10101, 8'h01));
`ifdef VECTOR_SEQUENCER_EXPECT_CHECK_EN
    check_val("wr_start pass", 32'(pass), 32'(1));
`endif

    // Asynchronous reset in the middle of RUN, away from any clock edge.
    @(negedge Clock);
    start      = 1'b1;
    display_in = 8'h01;
    @(negedge Clock);
    start = 1'b0;
    repeat (5) @(negedge Clock);
    check_val("midrun busy", 32'(busy), 32'(1));
    check_val("midrun idx", 32'(vec_index), 32'(1));
    check_val("midrun sig", 32'(signature), 32'h0001);
    #2;
    Resetn = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    check_reset("post_rst_idle");

    do_run("after_rst", DW'($urandom), 1'b0, 1'b0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
